// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg: shared state encoding, statistic widths and period helper.
package tick_scheduler_pkg;
    typedef enum logic [1:0] {PAUSE, RUN, STEP} state_e;
    localparam int MISSED_W = 4;
    localparam int COUNT_W = 8;
    function automatic logic [31:0] period_of(input logic [1:0] rate_sel, input int base_shift);
        return 32'd1 << (base_shift + int'(rate_sel));
    endfunction
endpackage

// File: rtl/tick_period_counter.sv
// tick_period_counter: loadable period counter with expiry flag and registered rate_sel compare.
module tick_period_counter
    import tick_scheduler_pkg::*;
#(
    parameter int BASE_SHIFT = 22,
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] rate_sel_i,
    input  logic       load_i,
    input  logic       en_i,
    output logic       expire_o
);
    logic [1:0] rate_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, last;
    logic rate_chg, at_last;
    assign last = CNT_W'(period_of(rate_q, BASE_SHIFT) - 32'd1);
    assign rate_chg = rate_sel_i != rate_q;
    assign at_last = cnt_q == last;
    // A rate change restarts the period and swallows any expiry on that edge.
    assign expire_o = en_i && !rate_chg && at_last;
    always_comb begin
        cnt_d = (load_i || rate_chg) ? '0 : en_i ? (at_last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_q <= '0;
            cnt_q  <= '0;
        end else begin
            rate_q <= rate_sel_i;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: paced tick-request generator with pause/step control and ack handshake.
// Optional TICK_OVERRUN_EN adds dropped-tick statistics (missed, overrun).
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int BASE_SHIFT = 22,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          rate_sel,
    input  logic                run_en,
    input  logic                step_req,
    input  logic                clear,
    output logic                tick_valid,
    input  logic                tick_ack,
    output logic                running,
    output logic [COUNT_W-1:0]  tick_count,
    output logic [MISSED_W-1:0] missed,
    output logic                overrun
);
    state_e state_q;
    logic running_q, step_q, valid_q, valid_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic expire, step_go, raise, accept;

    tick_period_counter #(.BASE_SHIFT(BASE_SHIFT), .CNT_W(CNT_W)) u_period (
        .clk        (clk),
        .reset_n    (reset_n),
        .rate_sel_i (rate_sel),
        .load_i     (state_q == PAUSE && run_en),
        .en_i       (state_q == RUN && run_en),
        .expire_o   (expire)
    );

    // step_req is captured first so STEP is entered, and its tick raised, one edge later.
    assign step_go = state_q == PAUSE && step_q && !run_en;
    assign raise = expire || step_go;
    assign accept = valid_q && tick_ack;

    always_comb begin
        valid_d = raise || (valid_q && !tick_ack);
        count_d = clear ? '0 : accept ? count_q + COUNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
            step_q    <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            step_q  <= step_req && state_q == PAUSE && !run_en;
            valid_q <= valid_d;
            count_q <= count_d;
            case (state_q)
                PAUSE: begin
                    if (run_en) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (step_go) begin
                        state_q <= STEP;
                    end
                end
                RUN: begin
                    if (!run_en) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick_valid = valid_q;
    assign running = running_q;
    assign tick_count = count_q;

`ifdef TICK_OVERRUN_EN
    logic [MISSED_W-1:0] missed_q, missed_d;
    logic over_q, over_d, drop;
    assign drop = raise && valid_q && !accept;
    always_comb begin
        missed_d = clear ? '0 : (drop && !(&missed_q)) ? missed_q + MISSED_W'(1) : missed_q;
        over_d = clear ? 1'b0 : over_q || drop;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            missed_q <= '0;
            over_q   <= 1'b0;
        end else begin
            missed_q <= missed_d;
            over_q   <= over_d;
        end
    end
    assign missed = missed_q;
    assign overrun = over_q;
`else
    assign missed = '0;
    assign overrun = 1'b0;
`endif
endmodule
